hpio_tx_ctrl: RTL and testbench

Bring-up sequencer and data scheduler for the HPIO_TX native-mode transmit core. It drives the core's reset and VTC enables, waits in order for PLL lock, reset-sequence done, delay-ready and VTC-ready, then sends a training burst before granting the serial data lane to a streaming payload source. It sits in the fabric clock domain between the data source, such as `counter_datagen`, and the `data_from_fabric_*` and status pins of HPIO_TX.

---
 rtl/hpio_tx_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hpio_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpio_tx_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hpio_tx_ctrl: HPIO_TX bring-up sequencer and transmit data scheduler.  |
// | Optional PRBS7 training/idle bytes with HPIO_TX_CTRL_PRBS_EN. Rev 1.0  |
// +------------------------------------------------------------------------+
module hpio_tx_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TRAIN_BEATS    = 256,
  parameter logic [7:0]  TRAIN_PATTERN  = 8'hAA,
  parameter logic [7:0]  IDLE_PATTERN   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll0_locked_i,
  input  logic       rst_seq_done_i,
  input  logic       dly_rdy_bsc3_i,
  input  logic       dly_rdy_bsc4_i,
  input  logic       vtc_rdy_bsc3_i,
  input  logic       vtc_rdy_bsc4_i,
  output logic       ip_rst_o,
  output logic       en_vtc_bsc3_o,
  output logic       en_vtc_bsc4_o,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] tx_data_o,
  output logic       link_up_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_SEQ  = 3'd2,
    ST_WAIT_DLY  = 3'd3,
    ST_WAIT_VTC  = 3'd4,
    ST_TRAIN     = 3'd5,
    ST_RUN       = 3'd6
  } state_t;

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_BEATS - 1);

  logic [5:0]  meta_q, sync_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        err_q, err_d;
  logic        ip_rst_q, en_vtc_q, s_ready_q, link_up_q;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        w_lock, w_seq, w_dly, w_vtc;
  logic        w_wait, w_lock_loss, w_timeout, w_accept;
  logic [7:0]  w_train_byte, w_idle_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {pll0_locked_i, rst_seq_done_i, dly_rdy_bsc3_i,
                 dly_rdy_bsc4_i, vtc_rdy_bsc3_i, vtc_rdy_bsc4_i};
      sync_q <= meta_q;
    end
  end

  assign w_lock      = sync_q[5];
  assign w_seq       = sync_q[4];
  assign w_dly       = &sync_q[3:2];
  assign w_vtc       = &sync_q[1:0];
  assign w_wait      = (state_q inside {ST_WAIT_LOCK, ST_WAIT_SEQ, ST_WAIT_DLY, ST_WAIT_VTC});
  assign w_lock_loss = !w_lock &&
                       (state_q inside {ST_WAIT_SEQ, ST_WAIT_DLY, ST_WAIT_VTC, ST_TRAIN, ST_RUN});
  assign w_timeout   = w_wait && (cnt_q == TO_LAST);
  assign w_accept    = s_ready_q && s_valid_i;

  // Lock loss outranks timeout, which outranks normal advance.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    err_d   = err_q;
    if (w_lock_loss) begin
      state_d = ST_RST;
    end else if (w_timeout) begin
      state_d = ST_RST;
      retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_RST:       if (cnt_q == RST_LAST)   state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: if (w_lock)              state_d = ST_WAIT_SEQ;
        ST_WAIT_SEQ:  if (w_seq)               state_d = ST_WAIT_DLY;
        ST_WAIT_DLY:  if (w_dly)               state_d = ST_WAIT_VTC;
        ST_WAIT_VTC:  if (w_vtc)               state_d = ST_TRAIN;
        ST_TRAIN:     if (cnt_q == TRAIN_LAST) state_d = ST_RUN;
        ST_RUN:       state_d = ST_RUN;
        default:      state_d = ST_RST;
      endcase
    end
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
  end

  always_comb begin
    tx_data_d = 8'h00;
    if (state_d == ST_TRAIN) begin
      tx_data_d = w_train_byte;
    end else if (state_d == ST_RUN) begin
      tx_data_d = w_accept ? s_data_i : w_idle_byte;
    end
  end

`ifdef HPIO_TX_CTRL_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic [6:0] lfsr_q, lfsr_d, w_prbs_src, w_prbs_next;
  logic [7:0] w_prbs_byte;

  // Eight steps of x^7+x^6+1; the first generated bit lands in the MSB.
  function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
    logic [6:0] r;
    logic [7:0] b;
    r = seed;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], r[6] ^ r[5]};
      r = {r[5:0], r[6] ^ r[5]};
    end
    return {b, r};
  endfunction

  assign w_prbs_src = (state_d == ST_TRAIN && state_q != ST_TRAIN) ? PRBS_SEED : lfsr_q;
  assign {w_prbs_byte, w_prbs_next} = prbs7_step8(w_prbs_src);
  assign w_train_byte = w_prbs_byte;
  assign w_idle_byte  = w_prbs_byte;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_d == ST_TRAIN || (state_d == ST_RUN && !w_accept)) lfsr_d = w_prbs_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= PRBS_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign w_train_byte = TRAIN_PATTERN;
  assign w_idle_byte  = IDLE_PATTERN;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
      ip_rst_q  <= 1'b1;
      en_vtc_q  <= 1'b0;
      s_ready_q <= 1'b0;
      link_up_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      ip_rst_q  <= (state_d == ST_RST);
      en_vtc_q  <= (state_d inside {ST_WAIT_VTC, ST_TRAIN, ST_RUN});
      s_ready_q <= (state_d == ST_RUN);
      link_up_q <= (state_d == ST_RUN);
      tx_data_q <= tx_data_d;
    end
  end

  assign ip_rst_o      = ip_rst_q;
  assign en_vtc_bsc3_o = en_vtc_q;
  assign en_vtc_bsc4_o = en_vtc_q;
  assign s_ready_o     = s_ready_q;
  assign tx_data_o     = tx_data_q;
  assign link_up_o     = link_up_q;
  assign state_o       = state_q;
  assign retry_cnt_o   = retry_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hpio_tx_ctrl.sv
`default_nettype none
// Bench for hpio_tx_ctrl: table-driven bring-up, payload stream against a model,
// lock loss, async reset mid-TRAIN and timeout retries.
module tb_hpio_tx_ctrl;
  localparam int TIMEOUT = 100;
  localparam int TRAIN_N = 256;
  localparam int GAP     = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll0_locked = 1'b0, rst_seq_done = 1'b0;
  logic       dly_rdy_bsc3 = 1'b0, dly_rdy_bsc4 = 1'b0;
  logic       vtc_rdy_bsc3 = 1'b0, vtc_rdy_bsc4 = 1'b0;
  logic       ip_rst, en_vtc_bsc3, en_vtc_bsc4;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       link_up;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hpio_tx_ctrl #(
    .RST_CYCLES    (16),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TRAIN_BEATS   (TRAIN_N),
    .TRAIN_PATTERN (8'hAA),
    .IDLE_PATTERN  (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll0_locked_i (pll0_locked),
    .rst_seq_done_i(rst_seq_done),
    .dly_rdy_bsc3_i(dly_rdy_bsc3),
    .dly_rdy_bsc4_i(dly_rdy_bsc4),
    .vtc_rdy_bsc3_i(vtc_rdy_bsc3),
    .vtc_rdy_bsc4_i(vtc_rdy_bsc4),
    .ip_rst_o      (ip_rst),
    .en_vtc_bsc3_o (en_vtc_bsc3),
    .en_vtc_bsc4_o (en_vtc_bsc4),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .tx_data_o     (tx_data),
    .link_up_o     (link_up),
    .state_o       (state),
    .retry_cnt_o   (retry_cnt),
    .err_o         (err)
  );

  // Status order: {pll0_locked, rst_seq_done, dly3, dly4, vtc3, vtc4}
  typedef struct packed {
    logic [5:0] status;
    logic [2:0] st_before;
    logic [2:0] st_after;
    logic       en_vtc;
  } step_t;

  step_t tbl [6];

  // PRBS7 reference: b[n] = b[n-7] ^ b[n-6], history seeded with seven ones.
  bit prbs_hist[$];

  function automatic void prbs_reseed();
    prbs_hist = {};
    repeat (7) prbs_hist.push_back(1'b1);
  endfunction

  function automatic logic [7:0] prbs_next_byte();
    logic [7:0] b;
    bit nb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nb = prbs_hist[0] ^ prbs_hist[1];
      prbs_hist.push_back(nb);
      void'(prbs_hist.pop_front());
      b = {b[6:0], nb};
    end
    return b;
  endfunction

  function automatic logic [7:0] exp_train_byte();
`ifdef HPIO_TX_CTRL_PRBS_EN
    return prbs_next_byte();
`else
    return 8'hAA;
`endif
  endfunction

  function automatic logic [7:0] exp_idle_byte();
`ifdef HPIO_TX_CTRL_PRBS_EN
    return prbs_next_byte();
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_status(input logic [5:0] s);
    {pll0_locked, rst_seq_done, dly_rdy_bsc3, dly_rdy_bsc4, vtc_rdy_bsc3, vtc_rdy_bsc4} = s;
  endtask

  task automatic apply_reset(input logic [5:0] st);
    rst_n = 1'b0;
    #1;
    check("rst_state",   state,       0);
    check("rst_ip_rst",  ip_rst,      1);
    check("rst_en3",     en_vtc_bsc3, 0);
    check("rst_en4",     en_vtc_bsc4, 0);
    check("rst_s_ready", s_ready,     0);
    check("rst_tx",      tx_data,     0);
    check("rst_link",    link_up,     0);
    check("rst_retry",   retry_cnt,   0);
    check("rst_err",     err,         0);
    s_valid = 1'b0;
    s_data  = 8'h00;
    set_status(st);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic bringup(input int n_train);
    int cyc;
    cyc = 0;
    while (ip_rst === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("ip_rst_len", cyc, 16);
    check("state_after_rst", state, 1);
    for (int i = 0; i < 6; i++) begin
      repeat (GAP) tick();
      set_status(tbl[i].status);
      tick();
      tick();
      check($sformatf("step%0d_before", i), state, tbl[i].st_before);
      tick();
      check($sformatf("step%0d_after", i), state, tbl[i].st_after);
      check($sformatf("step%0d_en3", i), en_vtc_bsc3, tbl[i].en_vtc);
      check($sformatf("step%0d_en4", i), en_vtc_bsc4, tbl[i].en_vtc);
      check($sformatf("step%0d_ip_rst", i), ip_rst, 0);
      check($sformatf("step%0d_link", i), link_up, 0);
    end
    prbs_reseed();
    for (int i = 0; i < n_train; i++) begin
      check("train_tx", tx_data, exp_train_byte());
      if (i == 0 || i == n_train - 1) begin
        check("train_state", state, 5);
        check("train_s_ready", s_ready, 0);
      end
      tick();
    end
    if (n_train == TRAIN_N) begin
      check("run_state", state, 6);
      check("run_link", link_up, 1);
      check("run_s_ready", s_ready, 1);
      check("run_first_tx", tx_data, exp_idle_byte());
    end
  endtask

  logic       v;
  logic [7:0] d, cnt8, exp_b;
  int         cyc;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{6'b100000, 3'd1, 3'd2, 1'b0};
    tbl[1] = '{6'b110000, 3'd2, 3'd3, 1'b0};
    tbl[2] = '{6'b111000, 3'd3, 3'd3, 1'b0};
    tbl[3] = '{6'b111100, 3'd3, 3'd4, 1'b1};
    tbl[4] = '{6'b111101, 3'd4, 3'd4, 1'b1};
    tbl[5] = '{6'b111111, 3'd4, 3'd5, 1'b1};

    #1;
    apply_reset(6'b000000);
    bringup(TRAIN_N);

    // Payload: counter with periodic gaps, then random traffic.
    cnt8 = 8'h00;
    for (int i = 0; i < 240; i++) begin
      if (i < 40) begin
        v = (i % 5 != 4);
        d = cnt8;
        if (v) cnt8 = cnt8 + 8'd1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end
      s_valid = v;
      s_data  = d;
      check("payload_s_ready", s_ready, 1);
      tick();
      exp_b = v ? d : exp_idle_byte();
      check("payload_tx", tx_data, exp_b);
    end

    // Lock loss mid-stream: beat in the exit cycle is dropped.
    s_valid = 1'b1;
    s_data  = 8'h5A;
    pll0_locked = 1'b0;
    tick();
    check("ll_tx1", tx_data, 8'h5A);
    check("ll_state1", state, 6);
    s_data = 8'hA5;
    tick();
    check("ll_state2", state, 6);
    check("ll_s_ready2", s_ready, 1);
    check("ll_tx2", tx_data, 8'hA5);
    s_data = 8'h3C;
    tick();
    check("ll_state3", state, 0);
    check("ll_s_ready3", s_ready, 0);
    check("ll_tx3", tx_data, 8'h00);
    check("ll_link3", link_up, 0);
    check("ll_ip_rst3", ip_rst, 1);
    check("ll_en3", en_vtc_bsc3, 0);
    check("ll_retry3", retry_cnt, 0);
    check("ll_err3", err, 0);
    s_valid = 1'b0;

    // Asynchronous reset in the middle of TRAIN, then full restart.
    apply_reset(6'b000000);
    bringup(100);
    #2;
    apply_reset(6'b000000);
    bringup(TRAIN_N);

    // Timeout retries in WAIT_SEQ with rst_seq_done held low.
    apply_reset(6'b100000);
    for (int a = 1; a <= 17; a++) begin
      cyc = 0;
      while (state !== 3'd2 && cyc < 100) begin
        tick();
        cyc++;
      end
      check("to_reach_wait_seq", state, 2);
      if (a == 1) begin
        check("to_err_before", err, 0);
        check("to_retry_before", retry_cnt, 0);
      end
      cyc = 0;
      while (state === 3'd2 && cyc < 300) begin
        tick();
        cyc++;
      end
      check("to_wait_cycles", cyc, TIMEOUT);
      check("to_state", state, 0);
      check("to_err", err, 1);
      check("to_retry", retry_cnt, (a > 15) ? 15 : a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
